// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared state encodings, symbol constants and helpers for the Genius round sequencer
//
// Purpose: one place for the FSM state encoding (also exported on state_o),
//          the 2-bit symbol values and the symbol-to-button mapping.
// Ports:   none (package).

package genius_pkg;

    localparam int BTN_W = 3;
    localparam int SYM_W = 2;

    // Encodings are visible outside the block through state_o, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GAP        = 3'd1,
        ST_SHOW       = 3'd2,
        ST_WAIT_PRESS = 3'd3,
        ST_WAIT_REL   = 3'd4,
        ST_LEVEL_UP   = 3'd5,
        ST_WIN        = 3'd6,
        ST_LOSE       = 3'd7
    } state_t;

    localparam logic [SYM_W-1:0] SYM0     = 2'd0;
    localparam logic [SYM_W-1:0] SYM1     = 2'd1;
    localparam logic [SYM_W-1:0] SYM2     = 2'd2;
    localparam logic [SYM_W-1:0] SYM_NONE = 2'd3;

    // SYM_NONE maps to no button at all, so no press can ever match it.
    function automatic logic [BTN_W-1:0] sym_to_btn(input logic [SYM_W-1:0] sym);
        logic [BTN_W-1:0] onehot;
        onehot = '0;
        case (sym)
            SYM0:    onehot = 3'b001;
            SYM1:    onehot = 3'b010;
            SYM2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/genius_round_ctrl_if.sv
// rtl/genius_round_ctrl_if.sv - signal bundle between the round sequencer and its surroundings
//
// Purpose: groups the timebase, start, buttons, sequence-store and display/status
//          signals of genius_round_ctrl.
// Modports:
//   slave  - the sequencer: receives tick/start/btn/seq_symbol, drives the rest
//   master - the environment: drives tick/start/btn/seq_symbol, observes the rest
// Signals:
//   tick, start, btn[2:0], seq_symbol[1:0]            environment -> sequencer
//   seq_index, show_valid, show_symbol[1:0], level,
//   state_o[2:0], win, lose, busy                     sequencer -> environment

interface genius_round_ctrl_if #(
    parameter int LEVEL_W = 4
) ();
    logic               tick;
    logic               start;
    logic [2:0]         btn;
    logic [1:0]         seq_symbol;
    logic [LEVEL_W-1:0] seq_index;
    logic               show_valid;
    logic [1:0]         show_symbol;
    logic [LEVEL_W-1:0] level;
    logic [2:0]         state_o;
    logic               win;
    logic               lose;
    logic               busy;

    modport slave (
        input  tick, start, btn, seq_symbol,
        output seq_index, show_valid, show_symbol, level, state_o, win, lose, busy
    );

    modport master (
        output tick, start, btn, seq_symbol,
        input  seq_index, show_valid, show_symbol, level, state_o, win, lose, busy
    );
endinterface

// File: rtl/genius_press_detect.sv
// rtl/genius_press_detect.sv - button press edge detector for the Genius round sequencer
//
// Purpose: keeps last cycle's buttons and flags a press only when the buttons
//          leave the all-released state, so a button held across a phase change
//          must be released before it counts.
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous active-low reset
//   btn[2:0]      in   synchronised buttons, 1 = pressed
//   press_evt     out  buttons went from all-released to something pressed
//   press_onehot  out  exactly one button is pressed this cycle
//   all_released  out  no button is pressed this cycle

module genius_press_detect
    import genius_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [BTN_W-1:0] btn,
    output logic             press_evt,
    output logic             press_onehot,
    output logic             all_released
);

    logic [BTN_W-1:0] btn_prev;

    // History resets to all-pressed so a button held through reset is not a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev <= '1;
        end else begin
            btn_prev <= btn;
        end
    end

    assign all_released = (btn == '0);
    assign press_evt    = (btn_prev == '0) && !all_released;
    assign press_onehot = !all_released && ((btn & (btn - 1'b1)) == '0);

endmodule

// File: rtl/genius_round_ctrl.sv
// rtl/genius_round_ctrl.sv - Genius game round sequencer: playback, press judging, level/win/lose
//
// Purpose: plays the stored sequence with timed on/gap phases, then judges one
//          press per release against the store, advancing the level or
//          reporting win/lose.
// Optional feature: GENIUS_TIMEOUT_EN - when defined, a press must arrive within
//          TIMEOUT_TICKS tick pulses of entering WAIT_PRESS or the round is lost.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   bus     slave modport of genius_round_ctrl_if:
//           tick, start, btn, seq_symbol in; seq_index, show_valid,
//           show_symbol, level, state_o, win, lose, busy out

module genius_round_ctrl
    import genius_pkg::*;
#(
    parameter int LEVEL_W       = 4,
    parameter int MAX_LEVEL     = 15,
    parameter int ON_TICKS      = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 40,
    parameter int TMR_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    genius_round_ctrl_if.slave bus
);

    // Elaboration-time sanity checks on the parameter set.
    if (MAX_LEVEL >= (1 << LEVEL_W)) begin : g_bad_max_level
        $error("MAX_LEVEL does not fit in LEVEL_W");
    end
    if ((ON_TICKS >= (1 << TMR_W)) || (GAP_TICKS >= (1 << TMR_W)) ||
        (TIMEOUT_TICKS >= (1 << TMR_W))) begin : g_bad_tmr_w
        $error("TMR_W too narrow for the tick counts");
    end

    localparam logic [TMR_W-1:0]   GAP_LAST = TMR_W'(GAP_TICKS - 1);
    localparam logic [TMR_W-1:0]   ON_LAST  = TMR_W'(ON_TICKS - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);
`ifdef GENIUS_TIMEOUT_EN
    localparam logic [TMR_W-1:0]   TO_LAST  = TMR_W'(TIMEOUT_TICKS - 1);
`endif

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [LEVEL_W-1:0] level, level_nxt;
    logic [LEVEL_W-1:0] idx, idx_nxt;
    logic               timer_run;

    logic               press_evt;
    logic               press_onehot;
    logic               all_released;
    logic               press_ok;

    genius_press_detect u_press (
        .clock        (clock),
        .reset        (reset),
        .btn          (bus.btn),
        .press_evt    (press_evt),
        .press_onehot (press_onehot),
        .all_released (all_released)
    );

    // A SYM_NONE store entry maps to 3'b000, which a real press never equals.
    assign press_ok = press_onehot && (bus.btn == sym_to_btn(bus.seq_symbol));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            timer <= '0;
            level <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            level <= level_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        idx_nxt   = idx;
        timer_run = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    level_nxt = '0;
                    idx_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                timer_run = 1'b1;
                if (bus.tick && (timer == GAP_LAST)) begin
                    state_nxt = ST_SHOW;
                end
            end

            ST_SHOW: begin
                timer_run = 1'b1;
                if (bus.tick && (timer == ON_LAST)) begin
                    if (idx < level) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_GAP;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = ST_WAIT_PRESS;
                    end
                end
            end

            ST_WAIT_PRESS: begin
`ifdef GENIUS_TIMEOUT_EN
                timer_run = 1'b1;
`endif
                // A press in the same cycle as timeout expiry takes priority.
                if (press_evt) begin
                    state_nxt = press_ok ? ST_WAIT_REL : ST_LOSE;
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (bus.tick && (timer == TO_LAST)) begin
                    state_nxt = ST_LOSE;
                end
`endif
            end

            ST_WAIT_REL: begin
                if (all_released) begin
                    if (idx == level) begin
                        state_nxt = ST_LEVEL_UP;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_WAIT_PRESS;
                    end
                end
            end

            ST_LEVEL_UP: begin
                if (level == LVL_MAX) begin
                    state_nxt = ST_WIN;
                end else begin
                    level_nxt = level + 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end

            ST_WIN:  state_nxt = ST_IDLE;
            ST_LOSE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Every state change restarts the timer; it only advances on tick pulses
        // in the timed phases.
        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (timer_run && bus.tick) begin
            timer_nxt = timer + 1'b1;
        end else begin
            timer_nxt = timer;
        end
    end

    // WIN and LOSE last exactly one cycle, so decoding them gives one-cycle pulses.
    assign bus.seq_index   = idx;
    assign bus.level       = level;
    assign bus.state_o     = state;
    assign bus.show_valid  = (state == ST_SHOW);
    assign bus.show_symbol = (state == ST_SHOW) ? bus.seq_symbol : SYM0;
    assign bus.win         = (state == ST_WIN);
    assign bus.lose        = (state == ST_LOSE);
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_genius_round_ctrl.sv
// tb/tb_genius_round_ctrl.sv - self-checking bench for genius_round_ctrl

module tb_genius_round_ctrl;
    import genius_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    genius_round_ctrl_if #(.LEVEL_W(4)) bus ();

    genius_round_ctrl #(
        .LEVEL_W       (4),
        .MAX_LEVEL     (3),
        .ON_TICKS      (4),
        .GAP_TICKS     (2),
        .TIMEOUT_TICKS (3),
        .TMR_W         (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [1:0] store [16];
    assign bus.seq_symbol = store[bus.seq_index];

    int         nchk = 0;
    int         nerr = 0;
    int         tcnt = 0;
    int         win_cnt = 0;
    int         lose_cnt = 0;
    logic       last_tick = 1'b0;
    logic [2:0] pre_state = 3'd0;

    typedef struct {
        logic [1:0] sym;
        logic [2:0] btn;
        logic [2:0] exp_state;
        logic       exp_lose;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: tick every 4th cycle, inputs change and outputs are sampled 1 after the edge.
    task automatic cyc();
        pre_state = bus.state_o;
        bus.tick  = (tcnt == 3);
        last_tick = bus.tick;
        @(posedge clock);
        #1;
        tcnt = (tcnt + 1) % 4;
        if (bus.win)  win_cnt++;
        if (bus.lose) lose_cnt++;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while ((int'(bus.state_o) != s) && (n < budget)) begin
            cyc();
            n++;
        end
        chk(name, int'(bus.state_o), s);
    endtask

    task automatic do_reset();
        bus.btn   = 3'b000;
        bus.start = 1'b0;
        reset     = 1'b0;
        cyc();
        cyc();
        reset     = 1'b1;
        cyc();
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // Press and release every symbol of a level in order.
    task automatic play_level(input int lvl);
        for (int i = 0; i <= lvl; i++) begin
            wait_state(3, 400, "play_wait_press");
            bus.btn = 3'b001 << store[i];
            cyc();
            bus.btn = 3'b000;
            cyc();
        end
    endtask

    initial begin
        int gap, show, n, nshow, gap_ticks, w0, l0;
        logic [1:0] syms [2];

        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.btn   = 3'b000;
        for (int i = 0; i < 16; i++) store[i] = 2'(2 - (i % 3));

        vecs[0] = '{2'd2, 3'b100, 3'd4, 1'b0};
        vecs[1] = '{2'd2, 3'b010, 3'd7, 1'b1};
        vecs[2] = '{2'd2, 3'b110, 3'd7, 1'b1};
        vecs[3] = '{2'd0, 3'b001, 3'd4, 1'b0};
        vecs[4] = '{2'd1, 3'b010, 3'd4, 1'b0};
        vecs[5] = '{2'd1, 3'b001, 3'd7, 1'b1};
        vecs[6] = '{2'd3, 3'b100, 3'd7, 1'b1};
        vecs[7] = '{2'd3, 3'b111, 3'd7, 1'b1};

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_state", int'(bus.state_o), 0);
        chk("rst_show_valid", int'(bus.show_valid), 0);
        chk("rst_seq_index", int'(bus.seq_index), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_win_lose_busy", int'({bus.win, bus.lose, bus.busy}), 0);
        do_reset();

        // Playback timing at level 0: tick phase aligned so the first tick lands 4 clocks after start.
        tcnt = 3;
        start_game();
        gap = 0;
        n = 0;
        while ((bus.state_o == 3'd1) && (n < 100)) begin gap++; cyc(); n++; end
        chk("gap_cycles", gap, 8);
        show = 0;
        n = 0;
        while ((bus.state_o == 3'd2) && (n < 100)) begin
            show++;
            chk("show_symbol", int'({bus.show_valid, bus.show_symbol}), 6);
            cyc();
            n++;
        end
        chk("show_cycles", show, 16);
        chk("after_show_state", int'(bus.state_o), 3);

        // Correct press at level 0, level up, replay of two symbols.
        bus.btn = 3'b100;
        cyc();
        chk("press_ok_state", int'(bus.state_o), 4);
        bus.btn = 3'b000;
        cyc();
        chk("level_up_state", int'(bus.state_o), 5);
        cyc();
        chk("level_after_up", int'(bus.level), 1);
        chk("gap_after_up", int'(bus.state_o), 1);
        nshow = 0;
        gap_ticks = 0;
        n = 0;
        while ((bus.state_o != 3'd3) && (n < 300)) begin
            cyc();
            n++;
            if ((pre_state == 3'd1) && last_tick && (nshow == 1)) gap_ticks++;
            if ((bus.state_o == 3'd2) && (pre_state != 3'd2)) begin
                if (nshow < 2) syms[nshow] = bus.show_symbol;
                nshow++;
            end
        end
        chk("replay_state", int'(bus.state_o), 3);
        chk("replay_nshow", nshow, 2);
        chk("replay_sym0", int'(syms[0]), 2);
        chk("replay_sym1", int'(syms[1]), 1);
        chk("replay_gap_ticks", gap_ticks, 2);

        // Table of single presses at level 0.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            store[0] = vecs[v].sym;
            start_game();
            wait_state(3, 200, "tbl_wait_press");
            bus.btn = vecs[v].btn;
            cyc();
            chk($sformatf("tbl%0d_state", v), int'(bus.state_o), int'(vecs[v].exp_state));
            chk($sformatf("tbl%0d_lose", v), int'(bus.lose), int'(vecs[v].exp_lose));
            bus.btn = 3'b000;
            cyc();
            cyc();
        end
        store[0] = 2'd2;

        // Wrong press: one-cycle lose pulse, level held.
        do_reset();
        start_game();
        wait_state(3, 200, "lose_wait_press");
        l0 = lose_cnt;
        bus.btn = 3'b010;
        cyc();
        chk("lose_pulse_on", int'(bus.lose), 1);
        bus.btn = 3'b000;
        cyc();
        chk("lose_pulse_off", int'(bus.lose), 0);
        chk("lose_to_idle", int'(bus.state_o), 0);
        chk("lose_level_held", int'(bus.level), 0);
        cyc();
        chk("lose_pulse_count", lose_cnt - l0, 1);

        // Button held from playback into WAIT_PRESS is ignored until released.
        do_reset();
        start_game();
        bus.btn = 3'b100;
        wait_state(3, 200, "held_wait_press");
        cyc();
        cyc();
        cyc();
        chk("held_ignored", int'(bus.state_o), 3);
        bus.btn = 3'b000;
        cyc();
        chk("held_released", int'(bus.state_o), 3);
        bus.btn = 3'b100;
        cyc();
        chk("held_then_press", int'(bus.state_o), 4);
        bus.btn = 3'b000;
        cyc();

        // Clearing MAX_LEVEL (3): one win pulse, level held at 3.
        do_reset();
        w0 = win_cnt;
        l0 = lose_cnt;
        start_game();
        for (int lvl = 0; lvl <= 3; lvl++) begin
            play_level(lvl);
            cyc();
            if (lvl < 3) chk($sformatf("win_run_level%0d", lvl), int'(bus.level), lvl + 1);
        end
        for (int i = 0; i < 4; i++) cyc();
        chk("win_pulse_count", win_cnt - w0, 1);
        chk("win_no_lose", lose_cnt - l0, 0);
        chk("win_level_held", int'(bus.level), 3);
        chk("win_to_idle", int'(bus.state_o), 0);

        // Asynchronous reset in the middle of SHOW at level 3.
        do_reset();
        start_game();
        for (int lvl = 0; lvl < 3; lvl++) begin
            play_level(lvl);
            cyc();
        end
        chk("mid_level3", int'(bus.level), 3);
        wait_state(2, 400, "mid_wait_show");
        w0 = win_cnt;
        l0 = lose_cnt;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", int'(bus.state_o), 0);
        chk("mid_rst_show_valid", int'(bus.show_valid), 0);
        chk("mid_rst_seq_index", int'(bus.seq_index), 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("mid_rst_no_pulse", (win_cnt - w0) + (lose_cnt - l0), 0);
        chk("mid_rst_idle", int'(bus.state_o), 0);

        // Press timeout
        do_reset();
        start_game();
        wait_state(3, 200, "to_wait_press");
`ifdef GENIUS_TIMEOUT_EN
        gap_ticks = 0;
        n = 0;
        while ((bus.state_o == 3'd3) && (n < 100)) begin
            cyc();
            n++;
            if ((pre_state == 3'd3) && last_tick) gap_ticks++;
        end
        chk("timeout_lose", int'(bus.state_o), 7);
        chk("timeout_ticks", gap_ticks, 3);
`else
        for (int i = 0; i < 40; i++) cyc();
        chk("no_timeout_wait", int'(bus.state_o), 3);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
